// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures register-file operands (with same-cycle
// writeback bypass), immediate and control bundle; detects load-use hazards
// and converts them or a branch flush into a bubble.
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [4:0]       id_rs1_index,
    input  logic [4:0]       id_rs2_index,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       id_rd_index,
    input  logic [3:0]       id_alu_op,
    input  logic             id_alu_src,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_reg_write,
    input  logic [XLEN-1:0]  rs1_data_in,
    input  logic [XLEN-1:0]  rs2_data_in,
    input  logic             wb_en,
    input  logic [4:0]       wb_rd_index,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             flush,
    output logic             stall,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_imm,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [4:0]       ex_rs1_index,
    output logic [4:0]       ex_rs2_index,
    output logic [4:0]       ex_rd_index,
    output logic [3:0]       ex_alu_op,
    output logic             ex_alu_src,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_reg_write,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [XLEN-1:0] rs1_bypassed;
    logic [XLEN-1:0] rs2_bypassed;
    logic            hazard;
    logic            load_in_ex;

    // Writeback bypass: the register file cannot return data written this same cycle, x0 never bypasses
    always_comb begin
        rs1_bypassed = rs1_data_in;
        rs2_bypassed = rs2_data_in;
        if (wb_en && (wb_rd_index != 5'd0) && (wb_rd_index == id_rs1_index))
            rs1_bypassed = wb_data;
        if (wb_en && (wb_rd_index != 5'd0) && (wb_rd_index == id_rs2_index))
            rs2_bypassed = wb_data;
    end

    // Load-use detect against the instruction currently in EX; a flush suppresses the stall
    always_comb begin
        load_in_ex = ex_valid && ex_mem_read && ex_reg_write && (ex_rd_index != 5'd0);
        hazard     = load_in_ex && id_valid &&
                     ((id_use_rs1 && (id_rs1_index == ex_rd_index)) ||
                      (id_use_rs2 && (id_rs2_index == ex_rd_index)));
        stall      = hazard && !flush;
    end

    // EX bundle capture: flush beats hazard, both insert an all-zero bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_imm       <= '0;
            ex_rs1_data  <= '0;
            ex_rs2_data  <= '0;
            ex_rs1_index <= '0;
            ex_rs2_index <= '0;
            ex_rd_index  <= '0;
            ex_alu_op    <= '0;
            ex_alu_src   <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_reg_write <= 1'b0;
        end else if (flush || hazard) begin
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_imm       <= '0;
            ex_rs1_data  <= '0;
            ex_rs2_data  <= '0;
            ex_rs1_index <= '0;
            ex_rs2_index <= '0;
            ex_rd_index  <= '0;
            ex_alu_op    <= '0;
            ex_alu_src   <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_reg_write <= 1'b0;
        end else begin
            ex_valid     <= id_valid;
            ex_pc        <= id_pc;
            ex_imm       <= id_imm;
            ex_rs1_data  <= rs1_bypassed;
            ex_rs2_data  <= rs2_bypassed;
            ex_rs1_index <= id_rs1_index;
            ex_rs2_index <= id_rs2_index;
            ex_rd_index  <= id_rd_index;
            ex_alu_op    <= id_valid ? id_alu_op : 4'd0;
            ex_alu_src   <= id_valid && id_alu_src;
            ex_mem_read  <= id_valid && id_mem_read;
            ex_mem_write <= id_valid && id_mem_write;
            ex_reg_write <= id_valid && id_reg_write && (id_rd_index != 5'd0);
        end
    end

    // Saturating count of bubbles inserted for load-use hazards only
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (stall && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage: reset, capture, bypass, load-use,
// flush priority and counter saturation (counter narrowed to keep the run short).
module tb_id_ex_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid;
    logic [XLEN-1:0]  id_pc;
    logic [XLEN-1:0]  id_imm;
    logic [4:0]       id_rs1_index;
    logic [4:0]       id_rs2_index;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [4:0]       id_rd_index;
    logic [3:0]       id_alu_op;
    logic             id_alu_src;
    logic             id_mem_read;
    logic             id_mem_write;
    logic             id_reg_write;
    logic [XLEN-1:0]  rs1_data_in;
    logic [XLEN-1:0]  rs2_data_in;
    logic             wb_en;
    logic [4:0]       wb_rd_index;
    logic [XLEN-1:0]  wb_data;
    logic             flush;
    logic             stall;
    logic             ex_valid;
    logic [XLEN-1:0]  ex_pc;
    logic [XLEN-1:0]  ex_imm;
    logic [XLEN-1:0]  ex_rs1_data;
    logic [XLEN-1:0]  ex_rs2_data;
    logic [4:0]       ex_rs1_index;
    logic [4:0]       ex_rs2_index;
    logic [4:0]       ex_rd_index;
    logic [3:0]       ex_alu_op;
    logic             ex_alu_src;
    logic             ex_mem_read;
    logic             ex_mem_write;
    logic             ex_reg_write;
    logic [CNT_W-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_pc(id_pc), .id_imm(id_imm),
        .id_rs1_index(id_rs1_index), .id_rs2_index(id_rs2_index),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd_index(id_rd_index), .id_alu_op(id_alu_op), .id_alu_src(id_alu_src),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
        .rs1_data_in(rs1_data_in), .rs2_data_in(rs2_data_in),
        .wb_en(wb_en), .wb_rd_index(wb_rd_index), .wb_data(wb_data),
        .flush(flush), .stall(stall),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_rs1_index(ex_rs1_index), .ex_rs2_index(ex_rs2_index),
        .ex_rd_index(ex_rd_index), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .stall_cnt(stall_cnt)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present one ID instruction; data/wb/flush fields are set separately
    task automatic applyStimulus(input logic valid, input logic [31:0] pc,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic use1, input logic use2, input logic [4:0] rd,
                                 input logic mr, input logic mw, input logic rw);
        id_valid     = valid;
        id_pc        = pc;
        id_rs1_index = rs1;
        id_rs2_index = rs2;
        id_use_rs1   = use1;
        id_use_rs2   = use2;
        id_rd_index  = rd;
        id_mem_read  = mr;
        id_mem_write = mw;
        id_reg_write = rw;
        #1;
    endtask

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        id_imm = '0; id_alu_op = '0; id_alu_src = 1'b0;
        rs1_data_in = '0; rs2_data_in = '0;
        wb_en = 1'b0; wb_rd_index = '0; wb_data = '0; flush = 1'b0;
        applyStimulus(1'b0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("reset_valid", {31'd0, ex_valid}, 32'd0);
        checkOutput("reset_cnt", {24'd0, stall_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Normal capture
        id_imm = 32'h44; id_alu_op = 4'd3; id_alu_src = 1'b1;
        rs1_data_in = 32'h11; rs2_data_in = 32'h22;
        applyStimulus(1'b1, 32'h100, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("cap_valid", {31'd0, ex_valid}, 32'd1);
        checkOutput("cap_pc", ex_pc, 32'h100);
        checkOutput("cap_rs1", ex_rs1_data, 32'h11);
        checkOutput("cap_rs2", ex_rs2_data, 32'h22);
        checkOutput("cap_rw", {31'd0, ex_reg_write}, 32'd1);
        checkOutput("cap_rd", {27'd0, ex_rd_index}, 32'd5);
        checkOutput("cap_imm", ex_imm, 32'h44);
        checkOutput("cap_op", {28'd0, ex_alu_op}, 32'd3);
        checkOutput("cap_src", {31'd0, ex_alu_src}, 32'd1);

        // rd=0 forces reg_write off; invalid ID forces controls off
        applyStimulus(1'b1, 32'h104, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("rd0_rw", {31'd0, ex_reg_write}, 32'd0);
        checkOutput("rd0_valid", {31'd0, ex_valid}, 32'd1);
        applyStimulus(1'b0, 32'h108, 5'd1, 5'd2, 1'b0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b1);
        tick();
        checkOutput("inv_valid", {31'd0, ex_valid}, 32'd0);
        checkOutput("inv_mr", {31'd0, ex_mem_read}, 32'd0);
        checkOutput("inv_op", {28'd0, ex_alu_op}, 32'd0);
        id_alu_op = 4'd0; id_alu_src = 1'b0;

        // Writeback bypass on rs1 only
        rs1_data_in = 32'h0; rs2_data_in = 32'h22;
        wb_en = 1'b1; wb_rd_index = 5'd7; wb_data = 32'hDEADBEEF;
        applyStimulus(1'b1, 32'h10C, 5'd7, 5'd8, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("byp_rs1", ex_rs1_data, 32'hDEADBEEF);
        checkOutput("byp_rs2_none", ex_rs2_data, 32'h22);
        // x0 never bypasses
        rs1_data_in = 32'h55; wb_rd_index = 5'd0;
        applyStimulus(1'b1, 32'h110, 5'd0, 5'd8, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("byp_x0", ex_rs1_data, 32'h55);
        // rs2 bypass, then wb_en low blocks it
        wb_rd_index = 5'd9; wb_data = 32'hCAFE;
        applyStimulus(1'b1, 32'h114, 5'd1, 5'd9, 1'b1, 1'b1, 5'd10, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("byp_rs2", ex_rs2_data, 32'hCAFE);
        wb_en = 1'b0;
        tick();
        checkOutput("byp_wb_off", ex_rs2_data, 32'h22);

        // Load-use on rs2: one bubble, then capture
        applyStimulus(1'b1, 32'h200, 5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 32'h204, 5'd4, 5'd3, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b1);
        checkOutput("lu_stall", {31'd0, stall}, 32'd1);
        tick();
        checkOutput("lu_bubble", {31'd0, ex_valid}, 32'd0);
        checkOutput("lu_cnt", {24'd0, stall_cnt}, 32'd1);
        checkOutput("lu_stall_drop", {31'd0, stall}, 32'd0);
        tick();
        checkOutput("lu_capture", {31'd0, ex_valid}, 32'd1);
        checkOutput("lu_capture_pc", ex_pc, 32'h204);

        // Same pairing with use_rs2=0: no stall
        applyStimulus(1'b1, 32'h208, 5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 32'h20C, 5'd4, 5'd3, 1'b1, 1'b0, 5'd6, 1'b0, 1'b0, 1'b1);
        checkOutput("nouse_stall", {31'd0, stall}, 32'd0);
        tick();
        checkOutput("nouse_valid", {31'd0, ex_valid}, 32'd1);
        checkOutput("nouse_cnt", {24'd0, stall_cnt}, 32'd1);

        // Load-use on rs1
        applyStimulus(1'b1, 32'h210, 5'd1, 5'd2, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 32'h214, 5'd6, 5'd2, 1'b1, 1'b0, 5'd7, 1'b0, 1'b0, 1'b1);
        checkOutput("lu1_stall", {31'd0, stall}, 32'd1);
        tick();
        checkOutput("lu1_cnt", {24'd0, stall_cnt}, 32'd2);

        // Flush beats hazard
        applyStimulus(1'b1, 32'h300, 5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1);
        tick();
        flush = 1'b1;
        applyStimulus(1'b1, 32'h304, 5'd4, 5'd3, 1'b1, 1'b1, 5'd6, 1'b0, 1'b1, 1'b0);
        checkOutput("fl_stall", {31'd0, stall}, 32'd0);
        tick();
        checkOutput("fl_valid", {31'd0, ex_valid}, 32'd0);
        checkOutput("fl_mw", {31'd0, ex_mem_write}, 32'd0);
        checkOutput("fl_cnt", {24'd0, stall_cnt}, 32'd2);
        // Flush with invalid ID after a valid EX instruction
        flush = 1'b0;
        applyStimulus(1'b1, 32'h308, 5'd1, 5'd2, 1'b0, 1'b0, 5'd8, 1'b0, 1'b0, 1'b1);
        tick();
        flush = 1'b1;
        applyStimulus(1'b0, 32'h30C, 5'd1, 5'd2, 1'b0, 1'b0, 5'd8, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("fl_inv_valid", {31'd0, ex_valid}, 32'd0);
        checkOutput("fl_inv_pc", ex_pc, 32'h0);
        flush = 1'b0;

        // Load to x0 followed by use of x0: no stall
        applyStimulus(1'b1, 32'h400, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 32'h404, 5'd0, 5'd0, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b1);
        checkOutput("x0_stall", {31'd0, stall}, 32'd0);
        tick();

        // Saturation: 2^CNT_W+3 load-use events on top of the 2 already counted
        for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
            applyStimulus(1'b1, 32'h500, 5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1);
            tick();
            applyStimulus(1'b1, 32'h504, 5'd3, 5'd2, 1'b1, 1'b0, 5'd6, 1'b0, 1'b0, 1'b1);
            tick();
        end
        checkOutput("sat_cnt", {24'd0, stall_cnt}, 32'h0000_00FF);

        // Reset asserted mid-stall clears immediately, then normal capture
        applyStimulus(1'b1, 32'h600, 5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 32'h604, 5'd3, 5'd2, 1'b1, 1'b0, 5'd6, 1'b0, 1'b0, 1'b1);
        checkOutput("rst_pre_stall", {31'd0, stall}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rst_async_valid", {31'd0, ex_valid}, 32'd0);
        checkOutput("rst_async_stall", {31'd0, stall}, 32'd0);
        checkOutput("rst_async_cnt", {24'd0, stall_cnt}, 32'd0);
        checkOutput("rst_async_pc", ex_pc, 32'h0);
        checkOutput("rst_async_mr", {31'd0, ex_mem_read}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        checkOutput("post_rst_valid", {31'd0, ex_valid}, 32'd1);
        checkOutput("post_rst_pc", ex_pc, 32'h604);
        checkOutput("post_rst_cnt", {24'd0, stall_cnt}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
Decode-to-execute pipeline register for the 5-stage core. It sits directly downstream of the register file:
- captures the two register-file read operands, the decoded immediate and the control bundle;
- bypasses same-cycle writeback data that the register file's combinational read cannot yet return;
- detects load-use hazards, holding IF/ID and inserting a bubble;
- handles branch flushes.
It is the sole producer of all EX-stage inputs.

Parameters:
XLEN, 32, operand/PC/immediate width
CNT_W, 16, width of saturating stall-event counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
id_valid  in  1  ID holds a real instruction
id_pc  in  XLEN  PC of ID instruction
id_imm  in  XLEN  decoded immediate
id_rs1_index  in  5  source 1 index (also drives register file)
id_rs2_index  in  5  source 2 index
id_use_rs1  in  1  instruction reads rs1
id_use_rs2  in  1  instruction reads rs2
id_rd_index  in  5  destination index
id_alu_op  in  4  ALU operation code
id_alu_src  in  1  1 = immediate as operand B
id_mem_read  in  1  load
id_mem_write  in  1  store
id_reg_write  in  1  writes rd
rs1_data_in  in  XLEN  register file rs1 read data
rs2_data_in  in  XLEN  register file rs2 read data
wb_en  in  1  writeback enable (same signal given to register file)
wb_rd_index  in  5  writeback destination
wb_data  in  XLEN  writeback data
flush  in  1  taken branch/jump resolved in EX; kill ID
stall  out  1  hold PC and IF/ID this cycle
ex_valid, ex_pc, ex_imm, ex_rs1_data, ex_rs2_data, ex_rs1_index, ex_rs2_index, ex_rd_index, ex_alu_op, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write  out  (widths as ID counterparts)  registered EX-stage bundle
stall_cnt  out  CNT_W  number of load-use bubbles inserted, saturating

Behaviour:
Reset (async, rst=1):
- every ex_* output clears to 0 (ex_valid=0, i.e. a bubble).
- stall_cnt clears to 0.
- stall reads 0 while rst is high.

Operand bypass (combinational, applied before capture), per source s in {rs1, rs2}:
- if wb_en=1 and wb_rd_index!=0 and wb_rd_index==id_s_index, the captured value is wb_data;
- otherwise the captured value is s_data_in.
- Index 0 is never bypassed and always captures s_data_in.

Hazard detect (combinational):
- hazard = ex_valid & ex_mem_read & ex_reg_write & (ex_rd_index!=0) & id_valid & ((id_use_rs1 & id_rs1_index==ex_rd_index) | (id_use_rs2 & id_rs2_index==ex_rd_index)).
- stall = hazard & ~flush.

Capture at each posedge, in priority order:
1. flush=1: load bubble. ex_valid=0 and all control bits (mem_read, mem_write, reg_write, alu_src, alu_op) are 0. Data fields are don't-care but driven 0. stall_cnt is unchanged.
2. hazard=1 (flush=0): load a bubble as above. stall_cnt increments, holding at all-ones.
3. Otherwise: load the ID bundle with bypassed operands. ex_valid=id_valid.
   - If id_valid=0, control bits are forced to 0.
   - If id_rd_index==0, ex_reg_write is forced to 0.

Timing and boundary cases:
- Latency is 1 cycle from ID inputs to ex_* outputs.
- A stalled ID instruction is re-presented next cycle by the upstream hold. After one bubble the load has left EX, so hazard drops and the instruction is captured. A single load-use costs exactly 1 bubble.
- Back-to-back load→load→use: each load-use pair is evaluated independently against the current EX contents only.
- Flush and hazard in the same cycle: flush wins, stall=0, no count.
- Flush while id_valid=0: still a bubble.
- Reset asserted mid-stall: outputs clear immediately. After release, the first edge captures normally.
- The block has no EX/MEM forwarding; that lives in EX.

Test Plan:
1. Reset: assert rst mid-run with ex_valid=1 → all ex_* outputs 0, stall_cnt=0, stall=0 with no clock edge required.
2. Normal capture: id_pc=0x100, rs1_data_in=0x11, rs2_data_in=0x22, rd=5, reg_write=1, no wb → next cycle ex_pc=0x100, ex_rs1_data=0x11, ex_rs2_data=0x22, ex_reg_write=1, ex_valid=1.
3. WB bypass: rs1_index=7, wb_en=1, wb_rd_index=7, wb_data=0xDEADBEEF, rs1_data_in=0x0 → ex_rs1_data=0xDEADBEEF. Repeat with wb_rd_index=0 and rs1_index=0 → ex_rs1_data=rs1_data_in.
4. Load-use: EX holds load with rd=3; ID uses rs2=3 → stall=1 that cycle; next cycle ex_valid=0 and stall_cnt=1; following cycle the ID instruction is captured with stall=0. Same case with id_use_rs2=0 → no stall.
5. Flush priority: hazard condition plus flush=1 → stall=0, next ex_valid=0, ex_mem_write=0, stall_cnt unchanged.
6. Saturation: force 2^CNT_W+3 load-use events → stall_cnt holds at 0xFFFF for CNT_W=16; rd=0 load followed by use of x0 → no stall.
